// File: rtl/hub75_rx.sv
// HUB75 link receiver: synchronizes the panel lines, captures each shifted row
// into a capture buffer and streams the latched row out with valid/ready.
module hub75_rx #(
    parameter int WIDTH    = 64,
    parameter int COL_BITS = 6,
    parameter int OE_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                H75_R1,
    input  logic                H75_G1,
    input  logic                H75_B1,
    input  logic                H75_R2,
    input  logic                H75_G2,
    input  logic                H75_B2,
    input  logic                H75_A,
    input  logic                H75_B,
    input  logic                H75_C,
    input  logic                H75_D,
    input  logic                H75_E,
    input  logic                H75_OE,
    input  logic                H75_Clk,
    input  logic                H75_Lat,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [4:0]          pix_line,
    output logic [COL_BITS-1:0] pix_col,
    output logic [5:0]          pix_rgb,
    output logic                pix_last,
    output logic                row_done,
    output logic [COL_BITS:0]   row_len,
    output logic                row_error,
    output logic [OE_BITS-1:0]  oe_on,
    output logic                overrun
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int                  NB       = COL_BITS + 1;
    localparam logic [NB-1:0]       WIDTH_N  = NB'(WIDTH);
    localparam logic [NB-1:0]       SAT_N    = NB'(WIDTH + 1);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);
    localparam logic [OE_BITS-1:0]  OE_MAX   = {OE_BITS{1'b1}};

    logic [13:0]         raw_s;
    logic [13:0]         sync1_r;
    logic [13:0]         sync2_r;
    logic [1:0]          prev_r;
    logic [5:0]          data_s;
    logic [4:0]          addr_s;
    logic                oe_s;
    logic                clk_rise_s;
    logic                lat_rise_s;

    logic [NB-1:0]       n_r;
    logic [NB-1:0]       n_shift_s;
    logic                wr_en_s;
    logic [OE_BITS-1:0]  oe_cnt_r;

    logic [5:0]          cap_buf_r  [WIDTH];
    logic [5:0]          cap_next_s [WIDTH];
    logic [5:0]          out_buf_r  [WIDTH];

    state_t              state_r;
    state_t              state_next_s;
    logic                accept_s;
    logic                advance_s;
    logic                overrun_set_s;
    logic [COL_BITS-1:0] col_inc_s;

    logic                pix_valid_r;
    logic [4:0]          pix_line_r;
    logic [COL_BITS-1:0] pix_col_r;
    logic [5:0]          pix_rgb_r;
    logic                pix_last_r;
    logic                row_done_r;
    logic [NB-1:0]       row_len_r;
    logic                row_error_r;
    logic [OE_BITS-1:0]  oe_on_r;
    logic                overrun_r;

    assign raw_s = {H75_Lat, H75_Clk, H75_OE,
                    H75_E, H75_D, H75_C, H75_B, H75_A,
                    H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2};

    assign data_s     = sync2_r[5:0];
    assign addr_s     = sync2_r[10:6];
    assign oe_s       = sync2_r[11];
    assign clk_rise_s = sync2_r[12] & ~prev_r[0];
    assign lat_rise_s = sync2_r[13] & ~prev_r[1];

    // Two-stage synchronizer on every panel line plus the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 14'd0;
            sync2_r <= 14'd0;
            prev_r  <= 2'd0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r[13:12];
        end
    end

    // Shift count after this cycle's Clk edge; a coincident latch sees it too.
    always_comb begin
        n_shift_s = n_r;
        wr_en_s   = 1'b0;
        if (clk_rise_s) begin
            wr_en_s = (n_r < WIDTH_N);
            if (n_r >= SAT_N) begin
                n_shift_s = SAT_N;
            end else begin
                n_shift_s = n_r + NB'(1);
            end
        end else begin
            n_shift_s = n_r;
        end
    end

    // Capture buffer contents including the word being shifted in this cycle.
    always_comb begin
        cap_next_s = cap_buf_r;
        if (wr_en_s) begin
            cap_next_s[n_r[COL_BITS-1:0]] = data_s;
        end else begin
            cap_next_s = cap_buf_r;
        end
    end

    // Pixel storage needs no reset; its contents are meaningless until a row lands.
    always_ff @(posedge clk) begin
        cap_buf_r <= cap_next_s;
        if (accept_s) begin
            out_buf_r <= cap_next_s;
        end
    end

    // Shift counter and OE-low cycle counter, both restarted by every latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r      <= '0;
            oe_cnt_r <= '0;
        end else if (lat_rise_s) begin
            n_r      <= '0;
            oe_cnt_r <= '0;
        end else begin
            n_r <= n_shift_s;
            if (!oe_s && (oe_cnt_r != OE_MAX)) begin
                oe_cnt_r <= oe_cnt_r + OE_BITS'(1);
            end
        end
    end

    // Stream state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign col_inc_s = pix_col_r + COL_BITS'(1);

    // Next state and per-cycle strobes; a latch during streaming is dropped.
    always_comb begin
        state_next_s  = state_r;
        accept_s      = 1'b0;
        advance_s     = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lat_rise_s) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                overrun_set_s = lat_rise_s;
                if (pix_ready) begin
                    if (pix_col_r == LAST_COL) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        advance_s    = 1'b1;
                        state_next_s = ST_STREAM;
                    end
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered pixel stream; the word for the next column is fetched on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_r <= 1'b0;
            pix_line_r  <= 5'd0;
            pix_col_r   <= '0;
            pix_rgb_r   <= 6'd0;
            pix_last_r  <= 1'b0;
            row_done_r  <= 1'b0;
        end else begin
            pix_valid_r <= (state_next_s == ST_STREAM);
            row_done_r  <= accept_s;
            if (accept_s) begin
                pix_line_r <= addr_s;
                pix_col_r  <= '0;
                pix_rgb_r  <= cap_next_s[0];
                pix_last_r <= (LAST_COL == COL_BITS'(0));
            end else if (advance_s) begin
                pix_col_r  <= col_inc_s;
                pix_rgb_r  <= out_buf_r[col_inc_s];
                pix_last_r <= (col_inc_s == LAST_COL);
            end
        end
    end

    // Row statistics follow every latch, whether the row was accepted or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_len_r   <= '0;
            row_error_r <= 1'b0;
            oe_on_r     <= '0;
            overrun_r   <= 1'b0;
        end else begin
            if (lat_rise_s) begin
                row_len_r   <= n_shift_s;
                row_error_r <= (n_shift_s != WIDTH_N);
                oe_on_r     <= oe_cnt_r;
            end
            overrun_r <= overrun_r | overrun_set_s;
        end
    end

    assign pix_valid = pix_valid_r;
    assign pix_line  = pix_line_r;
    assign pix_col   = pix_col_r;
    assign pix_rgb   = pix_rgb_r;
    assign pix_last  = pix_last_r;
    assign row_done  = row_done_r;
    assign row_len   = row_len_r;
    assign row_error = row_error_r;
    assign oe_on     = oe_on_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: drives HUB75 rows and checks the pixel stream and row
// statistics against a row-level model built from queues and arrays.
module tb_hub75_rx;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic r1 = 1'b0, g1 = 1'b0, b1 = 1'b0, r2 = 1'b0, g2 = 1'b0, b2 = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    logic oe = 1'b1, hclk = 1'b0, lat = 1'b0;
    logic pix_ready = 1'b0;
    logic pix_valid, pix_last, row_done, row_error, overrun;
    logic [4:0]  pix_line;
    logic [5:0]  pix_col;
    logic [5:0]  pix_rgb;
    logic [6:0]  row_len;
    logic [15:0] oe_on;

    hub75_rx #(.WIDTH(64), .COL_BITS(6), .OE_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .H75_R1(r1), .H75_G1(g1), .H75_B1(b1), .H75_R2(r2), .H75_G2(g2), .H75_B2(b2),
        .H75_A(a), .H75_B(b), .H75_C(c), .H75_D(d), .H75_E(e),
        .H75_OE(oe), .H75_Clk(hclk), .H75_Lat(lat),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_line(pix_line),
        .pix_col(pix_col), .pix_rgb(pix_rgb), .pix_last(pix_last),
        .row_done(row_done), .row_len(row_len), .row_error(row_error),
        .oe_on(oe_on), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] line; logic [5:0] col; logic [5:0] rgb; logic last; } word_t;
    typedef struct { int len; int err; int oe; } stat_t;

    word_t q[$];
    stat_t sq[$];
    logic [5:0] cap [W];
    int n = 0;
    int oe_acc = 0;
    int exp_len, exp_err, exp_oe;
    int pass_cnt = 0;
    int total_cnt = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s", name);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a shift lands at index n while the row is not yet full.
    task automatic model_shift(input logic [5:0] dat);
        if (n < W) cap[n] = dat;
        if (n < W + 1) n++;
    endtask

    // Model: an idle receiver takes the whole capture buffer, a busy one drops it.
    task automatic model_latch(input logic [4:0] addr);
        exp_len = n;
        exp_err = (n != W) ? 1 : 0;
        exp_oe  = oe_acc;
        if (q.size() == 0) begin
            for (int i = 0; i < W; i++)
                q.push_back('{line: addr, col: 6'(i), rgb: cap[i], last: (i == W - 1)});
            sq.push_back('{len: exp_len, err: exp_err, oe: exp_oe});
        end
        n = 0;
        oe_acc = 0;
    endtask

    task automatic set_data(input logic [5:0] dat);
        {r1, g1, b1, r2, g2, b2} = dat;
    endtask

    task automatic shift_col(input logic [5:0] dat);
        set_data(dat);
        tick(1);
        hclk = 1'b1;
        model_shift(dat);
        tick(2);
        hclk = 1'b0;
        tick(2);
    endtask

    task automatic shift_row(input int len, input bit rnd);
        for (int i = 0; i < len; i++)
            shift_col(rnd ? 6'($urandom) : 6'(i));
    endtask

    task automatic latch(input logic [4:0] addr);
        {e, d, c, b, a} = addr;
        tick(1);
        lat = 1'b1;
        model_latch(addr);
        tick(2);
        lat = 1'b0;
        tick(2);
    endtask

    task automatic oe_low(input int k);
        oe = 1'b0;
        tick(k);
        oe = 1'b1;
        oe_acc = (oe_acc + k > 65535) ? 65535 : oe_acc + k;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (q.size() != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        tick(2);
    endtask

    // Ready pattern driven just after each clock edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ($urandom_range(0, 3) != 0);
            default: pix_ready = 1'b0;
        endcase
    end

    // Scoreboard: every accepted word and every row_done pulse against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (row_done) begin
                if (sq.size() == 0) fail_now("row_done_unexpected");
                else begin
                    stat_t s;
                    s = sq.pop_front();
                    check("row_len", 32'(row_len), 32'(s.len));
                    check("row_error", 32'(row_error), 32'(s.err));
                    check("oe_on", 32'(oe_on), 32'(s.oe));
                end
            end
            if (pix_valid && pix_ready) begin
                if (q.size() == 0) fail_now("pix_valid_unexpected");
                else begin
                    word_t w;
                    w = q.pop_front();
                    check("pix_line", 32'(pix_line), 32'(w.line));
                    check("pix_col", 32'(pix_col), 32'(w.col));
                    check("pix_rgb", 32'(pix_rgb), 32'(w.rgb));
                    check("pix_last", 32'(pix_last), 32'(w.last));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_line", 32'(pix_line), 32'd0);
        check("rst_pix_col", 32'(pix_col), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_row_done", 32'(row_done), 32'd0);
        check("rst_row_len", 32'(row_len), 32'd0);
        check("rst_row_error", 32'(row_error), 32'd0);
        check("rst_oe_on", 32'(oe_on), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
    endtask

    // The cleared synchronizer presents OE low for two cycles after reset.
    task automatic release_reset();
        rst_n = 1'b1;
        oe_acc = 2;
        n = 0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        check_reset_outputs();
        release_reset();
        tick(2);

        // Full row, column-index data, row address 5.
        shift_row(W, 0);
        latch(5'd5);
        check("full_row_len", 32'(row_len), 32'd64);
        check("full_row_error", 32'(row_error), 32'd0);
        wait_drain();

        // Short row streams stale columns; long row saturates the count.
        shift_row(60, 1);
        latch(5'd9);
        check("short_row_len", 32'(row_len), 32'd60);
        check("short_row_error", 32'(row_error), 32'd1);
        wait_drain();
        shift_row(70, 1);
        latch(5'd17);
        check("long_row_len", 32'(row_len), 32'd65);
        check("long_row_error", 32'(row_error), 32'd1);
        wait_drain();

        // Stalled stream: a second latch is dropped and flags overrun.
        ready_mode = 2;
        shift_row(W, 1);
        latch(5'd3);
        shift_row(62, 1);
        latch(5'd4);
        tick(4);
        check("overrun_set", 32'(overrun), 32'd1);
        check("dropped_row_len", 32'(row_len), 32'd62);
        check("dropped_row_error", 32'(row_error), 32'd1);
        check("dropped_oe_on", 32'(oe_on), 32'(exp_oe));
        ready_mode = 0;
        wait_drain();
        check("overrun_sticky", 32'(overrun), 32'd1);

        // OE on-time measurement and saturation.
        oe_low(200);
        shift_row(W, 1);
        latch(5'd7);
        check("oe_on_200", 32'(oe_on), 32'd200);
        wait_drain();
        oe_low(70000);
        shift_row(W, 1);
        latch(5'd8);
        check("oe_on_sat", 32'(oe_on), 32'd65535);
        wait_drain();

        // Clk and Lat rising together after 63 shifts.
        shift_row(63, 1);
        {e, d, c, b, a} = 5'd30;
        set_data(6'h2d);
        tick(1);
        hclk = 1'b1;
        lat = 1'b1;
        model_shift(6'h2d);
        model_latch(5'd30);
        tick(2);
        hclk = 1'b0;
        lat = 1'b0;
        tick(2);
        check("coincident_row_len", 32'(row_len), 32'd64);
        wait_drain();

        // Randomized rows, random ready, random OE on-time.
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) oe_low($urandom_range(1, 300));
            shift_row($urandom_range(W - 4, W + 4), 1);
            wait_drain();
            latch(5'($urandom));
        end
        wait_drain();

        // Reset in the middle of a stream.
        ready_mode = 0;
        shift_row(W, 1);
        latch(5'd21);
        begin
            int k = 0;
            while (q.size() > W - 20 && k < 500) begin
                tick(1);
                k++;
            end
            if (q.size() > W - 20) fail_now("midstream_timeout");
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        sq.delete();
        tick(3);
        release_reset();
        tick(2);
        shift_row(W, 1);
        latch(5'd12);
        wait_drain();
        check("overrun_after_reset", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
